// File: rtl/gf2m_reduce_seq.sv
// Sequential GF(2^M) reduction of a PW-bit carry-less product, D fold steps per cycle.
// Optional GF_REDUCE_SQR_EN adds in_sqr: load the interleaved square of in_data[M-1:0].
module gf2m_reduce_seq #(
  parameter int M                = 113,
  parameter int PW               = 255,
  parameter logic [M-1:0] POLY_LO = 113'h201,
  parameter int D                = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
`ifdef GF_REDUCE_SQR_EN
  input  logic          in_sqr,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic          busy
);

  localparam int N  = (PW - M + D - 1) / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] ONE      = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] POLY_EXT = {{(PW-M){1'b0}}, POLY_LO};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   r;
  logic [PW-1:0]   fold;
  logic [PW-1:0]   load_val;
  logic [CW-1:0]   count;
  logic            load;
  logic            last;

`ifdef GF_REDUCE_SQR_EN
  function automatic logic [PW-1:0] spread(input logic [M-1:0] a);
    logic [PW-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (2 * i < PW) s = s | ({{(PW-1){1'b0}}, a[i]} << (2 * i));
    end
    return s;
  endfunction

  always_comb begin
    load_val = in_sqr ? spread(in_data[M-1:0]) : in_data;
  end
`else
  always_comb begin
    load_val = in_data;
  end
`endif

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign load      = in_valid && in_ready;
  assign last      = (count == CW'(N - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = (state == DONE) ? r[M-1:0] : '0;

  // D chained single-bit folds scanning downward from top; each fold only
  // creates bits below j, so later steps in the same scan pick them up.
  always_comb begin
    logic [PW-1:0] sh;
    int            top;
    int            j;
    fold = r;
    sh   = '0;
    top  = PW - 1 - int'(count) * D;
    j    = 0;
    for (int unsigned k = 0; k < D; k++) begin
      j = top - int'(k);
      if (j >= M && j < PW) begin
        sh = fold >> j;
        if (sh[0]) fold = fold ^ (ONE << j) ^ (POLY_EXT << (j - M));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE: begin
        if (load)           state_nxt = RUN;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        r     <= load_val;
        count <= '0;
      end else if (state == RUN) begin
        r     <= fold;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Self-checking bench for gf2m_reduce_seq against a polynomial long-division model.
module tb_gf2m_reduce_seq;

  localparam int M  = 113;
  localparam int PW = 255;
  localparam int D  = 16;
  localparam int N  = 9;
  localparam logic [M-1:0] POLY = 113'h201;
`ifdef GF_REDUCE_SQR_EN
  localparam bit SQR_EN = 1'b1;
`else
  localparam bit SQR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          in_sqr;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_data;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gf2m_reduce_seq #(.M(M), .PW(PW), .POLY_LO(POLY), .D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef GF_REDUCE_SQR_EN
    .in_sqr    (in_sqr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Textbook long division by F(x) = x^M + POLY(x).
  function automatic logic [M-1:0] model_mod(input logic [PW-1:0] p);
    logic [PW-1:0] f;
    f = {{(PW-M){1'b0}}, POLY} | ({{(PW-1){1'b0}}, 1'b1} << M);
    for (int j = PW - 1; j >= M; j--)
      if (p[j]) p = p ^ (f << (j - M));
    return p[M-1:0];
  endfunction

  function automatic logic [PW-1:0] model_load(input logic [PW-1:0] d, input logic s);
    logic [PW-1:0] q;
    if (!s) return d;
    q = '0;
    for (int i = 0; i < M; i++) q[2*i] = d[i];
    return q;
  endfunction

  function automatic logic [PW-1:0] rand_wide();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t = {t[223:0], $urandom()};
    return t[PW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [PW-1:0] d, input logic s);
    int g = 0;
    while (!in_ready && g < 100) begin tick(); g++; end
    in_valid = 1'b1;
    in_data  = d;
    in_sqr   = s;
    tick();
    in_valid = 1'b0;
    in_sqr   = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until out_valid.
  task automatic wait_done(output int lat, output int bz);
    lat = 0;
    bz  = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bz++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [PW-1:0] d, input logic s,
                        input logic [M-1:0] exp, input int hold);
    int lat, bz;
    logic [M-1:0] first;
    start(d, s);
    wait_done(lat, bz);
    check({tag, "_lat"}, 256'(lat), 256'(N));
    check({tag, "_busy"}, 256'(bz), 256'(N));
    check({tag, "_data"}, 256'(out_data), 256'(exp));
    first = out_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_data !== first || !out_valid) check({tag, "_hold"}, 256'(out_data), 256'(first));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, 256'(out_valid), 256'(0));
  endtask

  initial begin
    int lat, bz;
    logic [PW-1:0] d;
    logic s;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sqr = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_data", 256'(out_data), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 256'(in_ready), 256'(1));

    d = '0; d[113] = 1'b1;
    run_op("x113", d, 1'b0, 113'h201, 0);
    run_op("pass", 255'h1234, 1'b0, 113'h1234, 2);
    run_op("zero", '0, 1'b0, '0, 0);
    d = '0; d[122] = 1'b1;
    run_op("x122", d, 1'b0, (113'd1 << 18) | (113'd1 << 9), 1);
    run_op("ones", '1, 1'b0, model_mod('1), 0);

    // back-pressure then back-to-back accept on the consuming edge
    d = '0; d[113] = 1'b1;
    start(d, 1'b0);
    wait_done(lat, bz);
    check("bp_lat", 256'(lat), 256'(N));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable", 256'(out_data), 256'(113'h201));
      check("bp_in_ready", 256'(in_ready), 256'(0));
    end
    d = '0; d[122] = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = d;
    #1;
    check("b2b_in_ready", 256'(in_ready), 256'(1));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_busy", 256'(busy), 256'(1));
    check("b2b_valid_low", 256'(out_valid), 256'(0));
    wait_done(lat, bz);
    check("b2b_lat", 256'(lat), 256'(N));
    check("b2b_data", 256'(out_data), 256'((113'd1 << 18) | (113'd1 << 9)));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // reset during RUN cycle 4
    start('1, 1'b0);
    repeat (3) tick();
    check("mid_busy", 256'(busy), 256'(1));
    rst_n = 1'b0;
    tick();
    check("mid_out_valid", 256'(out_valid), 256'(0));
    check("mid_out_data", 256'(out_data), 256'(0));
    check("mid_busy_rst", 256'(busy), 256'(0));
    rst_n = 1'b1;
    tick();
    check("mid_in_ready", 256'(in_ready), 256'(1));
    repeat (N + 2) tick();
    check("mid_no_stale", 256'(out_valid), 256'(0));

    if (SQR_EN) begin
      run_op("sqr3", 255'h3, 1'b1, 113'h5, 0);
      d = '0; d[112] = 1'b1;
      run_op("sqr112", d, 1'b1,
             (113'd1 << 111) | (113'd1 << 16) | (113'd1 << 7), 0);
    end

    for (int n = 0; n < 24; n++) begin
      d = rand_wide();
      if ($urandom_range(0, 3) == 0) d[PW-1:M] = '0;
      s = SQR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op("rand", d, s, model_mod(model_load(d, s)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
